m_stage_dmem: RTL and testbench



---
 rtl/m_stage_dmem_pkg.sv | 55 +++++
 rtl/m_stage_dmem_dm_ext.sv | 28 ++
 rtl/m_stage_dmem.sv | 127 ++++++++++++
 tb/tb_m_stage_dmem.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/m_stage_dmem_pkg.sv
// Shared definitions for the M-stage data memory: opcodes, default geometry,
// the decoded memory-operation type and its alignment rule.
package m_stage_dmem_pkg;

    localparam int WORD_AW_DEF = 10;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [3:0] {
        MOP_NONE,
        MOP_LW,
        MOP_LB,
        MOP_LBU,
        MOP_LH,
        MOP_LHU,
        MOP_SW,
        MOP_SB,
        MOP_SH
    } mem_op_e;

    function automatic mem_op_e decode_op(input logic [5:0] op);
        mem_op_e t;
        case (op)
            OP_LW:   t = MOP_LW;
            OP_LB:   t = MOP_LB;
            OP_LBU:  t = MOP_LBU;
            OP_LH:   t = MOP_LH;
            OP_LHU:  t = MOP_LHU;
            OP_SW:   t = MOP_SW;
            OP_SB:   t = MOP_SB;
            OP_SH:   t = MOP_SH;
            default: t = MOP_NONE;
        endcase
        return t;
    endfunction

    // Words need lane 0; halves need an even lane; bytes never misalign.
    function automatic logic is_misaligned(input mem_op_e t, input logic [1:0] lane);
        logic m;
        case (t)
            MOP_LW, MOP_SW:          m = (lane != 2'b00);
            MOP_LH, MOP_LHU, MOP_SH: m = lane[0];
            default:                 m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/m_stage_dmem_dm_ext.sv
// Load extender: picks the byte/half addressed by the lane out of a memory
// word and sign- or zero-extends it; non-load types pass the raw word.
module m_stage_dmem_dm_ext
    import m_stage_dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  mem_op_e     i_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        // The half select ignores lane bit 0, so a misaligned half reads the aligned-down half.
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_op)
            MOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            MOP_LBU: o_data = {24'h0, w_byte};
            MOP_LH:  o_data = {{16{w_half[15]}}, w_half};
            MOP_LHU: o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/m_stage_dmem.sv
// M pipeline stage: data memory with byte/half/word stores and extended loads,
// followed by the M->W pipeline register.
module m_stage_dmem
    import m_stage_dmem_pkg::*;
#(
    parameter int WORD_AW = WORD_AW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC4_M,
    input  logic [31:0] PC8_M,
    input  logic [4:0]  A3_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] RT_M,
    input  logic        RegWrite_M,
    input  logic        MemWrite_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC4_W,
    output logic [31:0] PC8_W,
    output logic [4:0]  A3_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic        RegWrite_W,
    output logic        AlignErr_W
);

    localparam int DEPTH = 1 << WORD_AW;

    logic [31:0]        r_mem [DEPTH];
    logic [31:0]        r_ir       = '0;
    logic [31:0]        r_pc4      = '0;
    logic [31:0]        r_pc8      = '0;
    logic [4:0]         r_a3       = '0;
    logic [31:0]        r_ao       = '0;
    logic [31:0]        r_dr       = '0;
    logic               r_regwrite = 1'b0;
    logic               r_alignerr = 1'b0;

    mem_op_e            w_op;
    logic [WORD_AW-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_misalign;
    logic [31:0]        w_rd;
    logic [31:0]        w_wdata;
    logic               w_we;
    logic [31:0]        w_ext;

    always_comb begin
        w_op       = decode_op(IR_M[31:26]);
        w_idx      = AO_M[WORD_AW+1:2];
        w_lane     = AO_M[1:0];
        w_misalign = is_misaligned(w_op, w_lane);
        w_rd       = r_mem[w_idx];
    end

    // Merge the store data into the current word so every store is a full-word write.
    always_comb begin
        w_wdata = w_rd;
        w_we    = 1'b0;
        if (MemWrite_M && !w_misalign) begin
            case (w_op)
                MOP_SW: begin
                    w_wdata = RT_M;
                    w_we    = 1'b1;
                end
                MOP_SH: begin
                    if (w_lane[1]) w_wdata[31:16] = RT_M[15:0];
                    else           w_wdata[15:0]  = RT_M[15:0];
                    w_we = 1'b1;
                end
                MOP_SB: begin
                    w_wdata[{w_lane, 3'b000} +: 8] = RT_M[7:0];
                    w_we = 1'b1;
                end
                default: w_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    m_stage_dmem_dm_ext u_ext (
        .i_word (w_rd),
        .i_lane (w_lane),
        .i_op   (w_op),
        .o_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_pc4      <= '0;
            r_pc8      <= '0;
            r_a3       <= '0;
            r_ao       <= '0;
            r_dr       <= '0;
            r_regwrite <= 1'b0;
            r_alignerr <= 1'b0;
        end else begin
            r_ir       <= IR_M;
            r_pc4      <= PC4_M;
            r_pc8      <= PC8_M;
            r_a3       <= A3_M;
            r_ao       <= AO_M;
            r_dr       <= w_ext;
            r_regwrite <= RegWrite_M;
            r_alignerr <= w_misalign;
        end
    end

    assign IR_W       = r_ir;
    assign PC4_W      = r_pc4;
    assign PC8_W      = r_pc8;
    assign A3_W       = r_a3;
    assign AO_W       = r_ao;
    assign DR_W       = r_dr;
    assign RegWrite_W = r_regwrite;
    assign AlignErr_W = r_alignerr;

endmodule

// File: tb/tb_m_stage_dmem.sv
// Bench for m_stage_dmem: directed plan followed by random traffic, checked
// against a byte-addressed memory model through an expected-response queue.
module tb_m_stage_dmem;

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;
    localparam logic [5:0] RTYPE = 6'b000000, ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, PC4_M, PC8_M, AO_M, RT_M;
    logic [4:0]  A3_M;
    logic        RegWrite_M, MemWrite_M;
    logic [31:0] IR_W, PC4_W, PC8_W, AO_W, DR_W;
    logic [4:0]  A3_W;
    logic        RegWrite_W, AlignErr_W;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [4:0]  a3;
        logic [31:0] ao;
        logic [31:0] dr;
        logic        rw;
        logic        aerr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_mem [4096];
    int         n_vec = 0;
    int         n_err = 0;

    m_stage_dmem dut (
        .clk(clk), .reset(reset),
        .IR_M(IR_M), .PC4_M(PC4_M), .PC8_M(PC8_M), .A3_M(A3_M),
        .AO_M(AO_M), .RT_M(RT_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
        .IR_W(IR_W), .PC4_W(PC4_W), .PC8_W(PC8_W), .A3_W(A3_W),
        .AO_W(AO_W), .DR_W(DR_W), .RegWrite_W(RegWrite_W), .AlignErr_W(AlignErr_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {model_mem[b + 12'd3], model_mem[b + 12'd2], model_mem[b + 12'd1], model_mem[b]};
    endfunction

    // Issues one instruction into M and records the W-stage response the model predicts.
    task automatic issue(input logic rst, input logic [5:0] op, input logic [31:0] ao,
                         input logic [31:0] rt, input logic mw);
        exp_t        e;
        logic [31:0] ir, pc4;
        logic [11:0] a, h;
        logic [31:0] word;
        logic [15:0] half;
        logic [7:0]  byt;
        logic        mis;
        @(negedge clk);
        ir  = {op, 26'($urandom)};
        pc4 = $urandom;
        reset = rst; IR_M = ir; PC4_M = pc4; PC8_M = pc4 + 32'd4;
        A3_M = 5'($urandom); AO_M = ao; RT_M = rt;
        RegWrite_M = 1'($urandom); MemWrite_M = mw;
        if (rst) begin
            e = '0;
            for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;
        end else begin
            a    = ao[11:0];
            h    = {a[11:1], 1'b0};
            word = mem_word(a);
            byt  = model_mem[a];
            half = {model_mem[h + 12'd1], model_mem[h]};
            mis  = ((op == LW || op == SW) && a[1:0] != 2'b00) ||
                   ((op == LH || op == LHU || op == SH) && a[0]);
            e.ir = ir; e.pc4 = pc4; e.pc8 = pc4 + 32'd4; e.a3 = A3_M; e.ao = ao;
            e.rw = RegWrite_M; e.aerr = mis;
            case (op)
                LW:      e.dr = word;
                LB:      e.dr = 32'(signed'(byt));
                LBU:     e.dr = {24'h0, byt};
                LH:      e.dr = 32'(signed'(half));
                LHU:     e.dr = {16'h0, half};
                default: e.dr = word;
            endcase
            if (mw && !mis) begin
                case (op)
                    SW: for (int k = 0; k < 4; k++)
                            model_mem[{a[11:2], 2'b00} + 12'(k)] = rt[8*k +: 8];
                    SH: begin
                        model_mem[a]         = rt[7:0];
                        model_mem[a + 12'd1] = rt[15:8];
                    end
                    SB: model_mem[a] = rt[7:0];
                    default: ;
                endcase
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("IR_W",       IR_W,               e.ir);
                chk("PC4_W",      PC4_W,              e.pc4);
                chk("PC8_W",      PC8_W,              e.pc8);
                chk("A3_W",       {27'h0, A3_W},      {27'h0, e.a3});
                chk("AO_W",       AO_W,               e.ao);
                chk("DR_W",       DR_W,               e.dr);
                chk("RegWrite_W", {31'h0, RegWrite_W}, {31'h0, e.rw});
                chk("AlignErr_W", {31'h0, AlignErr_W}, {31'h0, e.aerr});
            end
        end
    end

    initial begin : stim
        logic [5:0] ops [10];
        logic [5:0] op;
        logic [31:0] ao;
        logic        mw;
        ops = '{LW, LB, LBU, LH, LHU, SW, SB, SH, RTYPE, ADDI};

        issue(1'b1, RTYPE, 32'h0, 32'h0, 1'b0);
        issue(1'b0, SW, 32'h0, 32'h5555AAAA, 1'b1);
        issue(1'b1, SW, 32'h0, 32'h12345678, 1'b1);
        issue(1'b0, LW, 32'h0, 32'h0, 1'b0);

        issue(1'b0, SW,  32'h10, 32'h89ABCDEF, 1'b1);
        issue(1'b0, LW,  32'h10, 32'h0, 1'b0);
        issue(1'b0, SB,  32'h11, 32'h00000012, 1'b1);
        issue(1'b0, LW,  32'h10, 32'h0, 1'b0);
        issue(1'b0, LB,  32'h13, 32'h0, 1'b0);
        issue(1'b0, LBU, 32'h13, 32'h0, 1'b0);
        issue(1'b0, SH,  32'h12, 32'h00007FFF, 1'b1);
        issue(1'b0, LH,  32'h12, 32'h0, 1'b0);
        issue(1'b0, SH,  32'h12, 32'h00008000, 1'b1);
        issue(1'b0, LH,  32'h12, 32'h0, 1'b0);
        issue(1'b0, LHU, 32'h12, 32'h0, 1'b0);
        issue(1'b0, SW,  32'h20, 32'h11223344, 1'b1);
        issue(1'b0, SW,  32'h21, 32'hDEADBEEF, 1'b1);
        issue(1'b0, LW,  32'h20, 32'h0, 1'b0);
        issue(1'b0, LH,  32'h23, 32'h0, 1'b0);
        issue(1'b0, SW,  32'h1000, 32'h00000001, 1'b1);
        issue(1'b0, LW,  32'h0, 32'h0, 1'b0);
        issue(1'b0, SW,  32'h4, 32'h00000099, 1'b0);
        issue(1'b0, LW,  32'h4, 32'h0, 1'b0);
        issue(1'b0, RTYPE, 32'h8, 32'hFFFFFFFF, 1'b1);
        issue(1'b0, LW,  32'h8, 32'h0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            op = ops[$urandom_range(0, 9)];
            ao = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) ao = ao | ($urandom & 32'hFFFFF000);
            mw = (op == SW || op == SB || op == SH) ? ($urandom_range(0, 5) != 0)
                                                    : ($urandom_range(0, 4) == 0);
            issue($urandom_range(0, 99) == 0, op, ao, $urandom, mw);
        end

        @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
